misao_fetch: RTL and testbench

//  - Instruction fetch stage of the MISA-O core; sits between the byte-wide memory port and the nibble decoder.
//  - Reads program bytes ahead of execution into a prefetch FIFO.
//  - Splits each byte into 4-bit opcodes, low nibble first, and hands them to the decoder on a valid/ready handshake.
//  - Flushes and restarts on a PC redirect (JAL/JMP/BEQZ/BC/RETI/SWI). Yields the memory port to the data unit when not granted.

---
 rtl/misao_pkg.sv | 13 +
 rtl/misao_fetch_if.sv | 20 ++
 rtl/misao_fetch_fifo.sv | 35 +++
 rtl/misao_fetch.sv | 69 ++++++
 tb/tb_misao_fetch.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/misao_pkg.sv
// misao_pkg: shared fetch-stage types, widths and FSM state encoding
package misao_pkg;
  localparam int MISAO_AW = 15;
  localparam int MISAO_NIB_W = 4;
  typedef logic [MISAO_NIB_W-1:0] nibble_t;
  typedef logic [MISAO_AW-1:0] baddr_t;
  typedef logic [MISAO_AW:0] npc_t;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
  typedef struct packed {
    baddr_t addr;
    logic [7:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/misao_fetch_if.sv
// misao_fetch_if: byte memory read port plus nibble valid/ready stream toward the decoder
interface misao_fetch_if;
  import misao_pkg::*;
  logic bus_gnt;
  logic mem_enable_read;
  baddr_t mem_addr;
  logic [7:0] mem_data_in;
  logic nib_valid;
  logic nib_ready;
  nibble_t nib_data;
  npc_t nib_pc;
  modport master (
    input bus_gnt, mem_data_in, nib_ready,
    output mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc
  );
  modport slave (
    output bus_gnt, mem_data_in, nib_ready,
    input mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc
  );
endinterface

// File: rtl/misao_fetch_fifo.sv
// misao_fetch_fifo: prefetch byte FIFO with synchronous clear and combinational head
module misao_fetch_fifo
  import misao_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/misao_fetch.sv
// misao_fetch: prefetching nibble fetch stage; define MISAO_FETCH_PERF_EN to build the perf counters
module misao_fetch
  import misao_pkg::*;
#(
  parameter int   DEPTH    = 4,
  parameter npc_t RESET_PC = 16'h0
) (
  input  logic                clk,
  input  logic                rst,
  misao_fetch_if.master       bus,
  input  logic                redirect_valid,
  input  npc_t                redirect_pc,
  input  logic                halt,
  output logic [15:0]         perf_stall_cnt,
  output logic [15:0]         perf_byte_cnt
);
  fetch_state_e state, state_nx;
  baddr_t fetch_addr;
  fetch_entry_t head;
  logic sel, full, empty, rd, take;
  always_ff @(posedge clk) state <= rst ? BOOT : state_nx;
  always_comb begin
    state_nx = redirect_valid ? FLUSH : RUN;
    rd = (state == RUN) & bus.bus_gnt & ~halt & ~full & ~redirect_valid;
  end
  assign take = bus.nib_valid & bus.nib_ready & ~redirect_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr <= RESET_PC[15:1];
      sel <= RESET_PC[0];
    end else if (redirect_valid) begin
      fetch_addr <= redirect_pc[15:1];
      sel <= redirect_pc[0];
    end else begin
      if (rd) fetch_addr <= fetch_addr + 1'b1;
      if (take) sel <= ~sel;
    end
  end
  misao_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .clr(rst | redirect_valid),
    .push(rd),
    .pop(take & sel),
    .din({fetch_addr, bus.mem_data_in}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  assign bus.mem_enable_read = rd;
  assign bus.mem_addr = fetch_addr;
  assign bus.nib_valid = ~empty;
  // outputs parked at a defined value while empty so reset shows nib_data=0, nib_pc=RESET_PC
  assign bus.nib_data = empty ? '0 : sel ? head.data[7:4] : head.data[3:0];
  assign bus.nib_pc = empty ? {fetch_addr, sel} : {head.addr, sel};
`ifdef MISAO_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_byte_cnt <= '0;
    end else begin
      if (bus.nib_ready & ~bus.nib_valid & ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (rd) perf_byte_cnt <= perf_byte_cnt + 1'b1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_byte_cnt = '0;
`endif
endmodule

// File: tb/tb_misao_fetch.sv
// tb_misao_fetch: directed, table-driven and random checks of misao_fetch against a nibble-stream model
module tb_misao_fetch;
  import misao_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, redirect_valid = 0, halt = 0;
  npc_t redirect_pc = '0;
  logic [15:0] perf_stall_cnt, perf_byte_cnt;
  logic [7:0] mem [32768];
  int n_cmp = 0, n_bad = 0;
  misao_fetch_if bus();
  misao_fetch #(.DEPTH(DEPTH), .RESET_PC(16'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_byte_cnt(perf_byte_cnt)
  );
  always #5 clk = ~clk;
  assign bus.mem_data_in = mem[bus.mem_addr];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic nibble_t nib_of(npc_t pc);
    logic [7:0] b;
    b = mem[pc[15:1]];
    return pc[0] ? b[7:4] : b[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: the delivered stream is consecutive nibble PCs from the last restart point,
  // reads are consecutive byte addresses, and buffered bytes never exceed DEPTH
  npc_t exp_pc;
  baddr_t exp_rd;
  int occ, rd_cnt;
  logic prev_rr = 1;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 16'h0;
      exp_rd = '0;
      occ = 0;
      rd_cnt = 0;
      prev_rr = 1;
    end else begin
      chk("valid_vs_model", 32'(bus.nib_valid), 32'(occ != 0));
      if (prev_rr) chk("no_read_after_restart", 32'(bus.mem_enable_read), 0);
      if (redirect_valid) begin
        chk("no_read_on_redirect", 32'(bus.mem_enable_read), 0);
        exp_pc = redirect_pc;
        exp_rd = redirect_pc[15:1];
        occ = 0;
      end else begin
        if (bus.nib_valid && bus.nib_ready) begin
          chk("stream_pc", 32'(bus.nib_pc), 32'(exp_pc));
          chk("stream_data", 32'(bus.nib_data), 32'(nib_of(exp_pc)));
          if (exp_pc[0]) occ--;
          exp_pc = exp_pc + 1'b1;
        end
        if (bus.mem_enable_read) begin
          chk("read_gate", 32'(bus.bus_gnt & ~halt), 1);
          chk("read_addr", 32'(bus.mem_addr), 32'(exp_rd));
          exp_rd = exp_rd + 1'b1;
          occ++;
          rd_cnt++;
          chk("occupancy", 32'(occ <= DEPTH), 1);
        end
      end
      prev_rr = redirect_valid;
    end
  end

  typedef struct {
    npc_t target;
    logic [7:0] bval;
    nibble_t exp_data;
    npc_t exp_pc;
  } redir_vec_t;
  redir_vec_t tbl [4];
  nibble_t first4 [4];
  int lat, n, hs;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0013, 8'hB7, 4'hB, 16'h0013};
    tbl[1] = '{16'h0000, 8'h5A, 4'hA, 16'h0000};
    tbl[2] = '{16'h0006, 8'h3C, 4'hC, 16'h0006};
    tbl[3] = '{16'h1235, 8'h9E, 4'h9, 16'h1235};
    first4 = '{4'h8, 4'h1, 4'hC, 4'h4};
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h18;
    mem[1] = 8'h4C;
    bus.bus_gnt = 1;
    bus.nib_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_nib_valid", 32'(bus.nib_valid), 0);
    chk("rst_read", 32'(bus.mem_enable_read), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_nib_data", 32'(bus.nib_data), 0);
    chk("rst_nib_pc", 32'(bus.nib_pc), 0);
    chk("rst_perf", 32'({perf_stall_cnt, perf_byte_cnt}), 0);
    step();
    rst = 0;
    lat = 0;
    @(negedge clk);
    while (!bus.nib_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("first_valid_latency", 32'(lat), 2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("boot_valid", 32'(bus.nib_valid), 1);
      chk("boot_data", 32'(bus.nib_data), 32'(first4[k]));
      chk("boot_pc", 32'(bus.nib_pc), 32'(k));
    end
    step();
`ifdef MISAO_FETCH_PERF_EN
    chk("perf_byte_cnt", 32'(perf_byte_cnt), 32'(rd_cnt));
    chk("perf_stall_cnt", 32'(perf_stall_cnt), 2);
`else
    chk("perf_tied_off", 32'({perf_stall_cnt, perf_byte_cnt}), 0);
`endif
    bus.nib_ready = 0;
    rst = 1;
    step();
    step();
    rst = 0;
    repeat (10) step();
    chk("reads_while_stalled", 32'(rd_cnt), DEPTH);
    chk("read_off_when_full", 32'(bus.mem_enable_read), 0);
    chk("held_pc", 32'(bus.nib_pc), 0);
    chk("held_data", 32'(bus.nib_data), 8);
    bus.nib_ready = 1;
    repeat (12) step();
    for (int t = 0; t < 4; t++) begin
      bus.nib_ready = 0;
      repeat (DEPTH + 3) step();
      chk("full_before_redirect", 32'(bus.mem_enable_read), 0);
      mem[tbl[t].target[15:1]] = tbl[t].bval;
      redirect_valid = 1;
      redirect_pc = tbl[t].target;
      @(negedge clk);
      step();
      redirect_valid = 0;
      @(negedge clk);
      chk("flush_no_valid", 32'(bus.nib_valid), 0);
      chk("flush_no_read", 32'(bus.mem_enable_read), 0);
      @(negedge clk);
      chk("target_read", 32'(bus.mem_enable_read), 1);
      chk("target_addr", 32'(bus.mem_addr), 32'(tbl[t].target[15:1]));
      chk("no_stale_valid", 32'(bus.nib_valid), 0);
      @(negedge clk);
      chk("redir_valid", 32'(bus.nib_valid), 1);
      chk("redir_data", 32'(bus.nib_data), 32'(tbl[t].exp_data));
      chk("redir_pc", 32'(bus.nib_pc), 32'(tbl[t].exp_pc));
      step();
      bus.nib_ready = 1;
      repeat (6) step();
    end
    for (int m = 0; m < 2; m++) begin
      repeat (3) step();
      if (m == 0) bus.bus_gnt = 0;
      else halt = 1;
      n = 0;
      hs = 0;
      repeat (5) begin
        @(negedge clk);
        n += 32'(bus.mem_enable_read);
        hs += 32'(bus.nib_valid & bus.nib_ready);
      end
      step();
      bus.bus_gnt = 1;
      halt = 0;
      chk(m == 0 ? "no_read_without_gnt" : "no_read_while_halt", 32'(n), 0);
      chk("drain_while_blocked", 32'(hs > 0), 1);
      repeat (10) step();
    end
    redirect_valid = 1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_read_hi", 32'({bus.mem_enable_read, bus.mem_addr}), 32'({1'b1, 15'h7FFF}));
    @(negedge clk);
    chk("wrap_read_lo", 32'({bus.mem_enable_read, bus.mem_addr}), 32'({1'b1, 15'h0000}));
    chk("wrap_pc0", 32'({bus.nib_valid, bus.nib_pc}), 32'({1'b1, 16'hFFFE}));
    @(negedge clk);
    chk("wrap_pc1", 32'({bus.nib_valid, bus.nib_pc}), 32'({1'b1, 16'hFFFF}));
    @(negedge clk);
    chk("wrap_pc2", 32'({bus.nib_valid, bus.nib_pc}), 32'({1'b1, 16'h0000}));
    step();
    for (int c = 0; c < 3000; c++) begin
      bus.bus_gnt = ($urandom % 4) != 0;
      halt = ($urandom % 8) == 0;
      bus.nib_ready = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc = 16'($urandom);
      rst = ($urandom % 600) == 0;
      step();
    end
    rst = 0;
    redirect_valid = 0;
    halt = 0;
    bus.bus_gnt = 1;
    bus.nib_ready = 1;
    repeat (8) step();
`ifndef MISAO_FETCH_PERF_EN
    chk("perf_tied_off_end", 32'({perf_stall_cnt, perf_byte_cnt}), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
